trap_csr_unit: RTL and testbench
================================

// Module: trap_csr_unit
// PURPOSE
//  Machine-mode trap/CSR sequencer feeding the PC register stage: owns the M-mode trap CSRs, serves
//  CSR instructions, and on exception/interrupt/mret runs a short FSM that stalls the PC register
//  (holds ld low) and then issues a one-cycle redirect with the new PC for that register to load.
// PARAMETERS
//  XLEN         32            data/address width
//  MTVEC_RESET  32'h0000_0000 reset value of mtvec
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, asynchronous, active-low
//  exc_valid    in   1     synchronous exception request from execute
//  exc_cause    in   4     exception code (mcause[3:0])
//  exc_pc       in   XLEN  PC of faulting instruction
//  exc_tval     in   XLEN  trap value (bad address/instruction)
//  irq_ext      in   1     level-sensitive external interrupt
//  retire_pc    in   XLEN  PC of next instruction to execute (interrupt mepc)
//  mret         in   1     mret instruction in execute
//  csr_en       in   1     CSR instruction valid
//  csr_op       in   2     01 RW, 10 RS (set), 11 RC (clear), 00 none
//  csr_addr     in   12    CSR address
//  csr_wdata    in   XLEN  rs1/zimm operand
//  csr_rdata    out  XLEN  old CSR value, combinational
//  csr_illegal  out  1     csr_en with unimplemented address
//  stall        out  1     hold PC register / pipeline (ld=0)
//  redirect     out  1     one-cycle pulse: PC register loads redirect_pc
//  redirect_pc  out  XLEN  target PC
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; stall=0, redirect=0, redirect_pc=0; MIE=MPIE=0, mie=0,
//   mtvec=MTVEC_RESET, mscratch=mepc=mcause=mtval=0.
//  CSR map: 300 mstatus (MIE b3, MPIE b7, MPP b12:11 reads 2'b11, rest 0); 304 mie (MEIE b11 only);
//   305 mtvec; 340 mscratch; 341 mepc (b1:0 read/write 0); 342 mcause (b31=interrupt, b3:0 code);
//   343 mtval; 344 mip read-only (MEIP b11 = irq_ext). Unknown addr: csr_illegal=1, rdata=0, no write.
//   Writes to mip ignored; RS/RC apply wdata as set/clear mask; read-only/unused bits unaffected.
//  CSR writes commit at the clock edge, only in IDLE and only if no trap/mret taken that cycle.
//  Trap-take in IDLE, priority: exc_valid > (irq_ext & MEIE & MIE) > mret > CSR write.
//  FSM (Moore outputs): IDLE -> SAVE -> JUMP -> IDLE for traps; IDLE -> RET -> IDLE for mret.
//   Entry edge (trap): mepc<=exc_pc (exc) or retire_pc (irq); mcause<={0,exc_cause} or {1,..,11};
//    mtval<=exc_tval (exc) or 0 (irq); MPIE<=MIE; MIE<=0.
//   SAVE: stall=1, redirect=0.  JUMP: stall=1, redirect=1, redirect_pc=mtvec base ({mtvec[31:2],2'b00});
//    if mtvec[1:0]==01 and interrupt: base + 4*cause(11) = base+44. mtvec[1:0]>=10 treated as direct.
//   RET: stall=0, redirect=1, redirect_pc=mepc; at exit edge MIE<=MPIE, MPIE<=1.
//  Latency: exc_valid in cycle N -> stall N+1,N+2; redirect N+2; IDLE N+3. mret N -> redirect N+1.
//  In SAVE/JUMP/RET all inputs ignored (no CSR writes, no new traps); csr_rdata still reflects state.
//  exc_valid during MIE=0 is still taken; interrupts never taken while MIE=0 or MEIE=0.
//  Async reset mid-sequence aborts it: IDLE, no redirect, CSRs to reset values.
// TESTING
//  1 Reset: rst=0 -> all outputs 0; read 0x305 -> MTVEC_RESET; read 0x300 -> 0x0000_1800.
//  2 CSR ops: RW 0x340 <= 0xA5A5_0000; RS 0x00FF -> rdata 0xA5A5_0000, then reads 0xA5A5_00FF;
//    RC 0xA500_0000 -> 0x00A5_00FF; addr 0x7C0 -> csr_illegal=1, no state change.
//  3 Exception: mtvec=0x100, MIE=1, exc_valid cause 2 pc 0x40 tval 0xDEAD -> stall N+1..N+2,
//    redirect N+2 to 0x100; mepc=0x40, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1.
//  4 Vectored irq: mtvec=0x201, mie=0x800, MIE=1, irq_ext=1, retire_pc=0x88 -> redirect 0x22C;
//    mcause=0x8000_000B; mepc=0x88; same with MIE=0 -> no trap.
//  5 mret: mepc=0x44, MPIE=1 -> redirect 0x44 next cycle, stall=0, MIE=1, MPIE=1.
//  6 Collisions: exc_valid+irq+mret+CSR write same cycle -> exception taken, CSR unchanged;
//    rst pulsed during SAVE -> no redirect, IDLE, CSRs at reset values.

Source files
------------

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR sequencer: owns the M-mode trap CSRs, serves CSR instructions and
// sequences exception/interrupt entry and mret into a stall-then-redirect of the PC register.
module trap_csr_unit #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_ext,
    input  logic [XLEN-1:0] retire_pc,
    input  logic            mret,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_JUMP,
        S_RET
    } state_t;

    state_t          r_state;
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic            r_meie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic            r_mcause_int;
    logic [3:0]      r_mcause_code;
    logic [XLEN-1:0] r_mtval;
    logic            r_stall;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mie;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_mepc;
    logic [XLEN-1:0] w_mcause;
    logic [XLEN-1:0] w_rdata;
    logic            w_legal;
    logic [XLEN-1:0] w_wval;
    logic            w_idle;
    logic            w_exc_take;
    logic            w_irq_take;
    logic            w_mret_take;
    logic            w_csr_we;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_trap_target;

    // Architectural views of the sparse CSRs; mepc is always read back word-aligned.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mstatus_mpie;
        w_mstatus[3]     = r_mstatus_mie;
        w_mie            = '0;
        w_mie[11]        = r_meie;
        w_mip            = '0;
        w_mip[11]        = irq_ext;
        w_mepc           = {r_mepc[XLEN-1:2], 2'b00};
        w_mcause         = '0;
        w_mcause[XLEN-1] = r_mcause_int;
        w_mcause[3:0]    = r_mcause_code;
    end

    always_comb begin
        w_rdata = '0;
        w_legal = 1'b1;
        case (csr_addr)
            A_MSTATUS:  w_rdata = w_mstatus;
            A_MIE:      w_rdata = w_mie;
            A_MTVEC:    w_rdata = r_mtvec;
            A_MSCRATCH: w_rdata = r_mscratch;
            A_MEPC:     w_rdata = w_mepc;
            A_MCAUSE:   w_rdata = w_mcause;
            A_MTVAL:    w_rdata = r_mtval;
            A_MIP:      w_rdata = w_mip;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_wval = w_rdata;
        case (csr_op)
            2'b01:   w_wval = csr_wdata;
            2'b10:   w_wval = w_rdata | csr_wdata;
            2'b11:   w_wval = w_rdata & ~csr_wdata;
            default: w_wval = w_rdata;
        endcase
    end

    assign csr_rdata   = w_rdata;
    assign csr_illegal = csr_en & ~w_legal;

    // Trap-take priority in IDLE: exception, then enabled interrupt, then mret, then CSR write.
    assign w_idle      = (r_state == S_IDLE);
    assign w_exc_take  = w_idle & exc_valid;
    assign w_irq_take  = w_idle & irq_ext & r_meie & r_mstatus_mie;
    assign w_mret_take = w_idle & mret;
    assign w_csr_we    = w_idle & csr_en & (csr_op != 2'b00) & w_legal
                         & ~w_exc_take & ~w_irq_take & ~w_mret_take;

    assign w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_trap_target = ((r_mtvec[1:0] == 2'b01) && r_mcause_int)
                           ? w_tvec_base + XLEN'({r_mcause_code, 2'b00})
                           : w_tvec_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_meie         <= 1'b0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause_int   <= 1'b0;
            r_mcause_code  <= '0;
            r_mtval        <= '0;
            r_stall        <= 1'b0;
            r_redirect     <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_exc_take || w_irq_take) begin
                        r_state        <= S_SAVE;
                        r_stall        <= 1'b1;
                        r_mstatus_mpie <= r_mstatus_mie;
                        r_mstatus_mie  <= 1'b0;
                        r_mcause_int   <= ~w_exc_take;
                        r_mepc         <= w_exc_take ? exc_pc    : retire_pc;
                        r_mcause_code  <= w_exc_take ? exc_cause : 4'd11;
                        r_mtval        <= w_exc_take ? exc_tval  : '0;
                    end else if (w_mret_take) begin
                        r_state       <= S_RET;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_mepc;
                    end else if (w_csr_we) begin
                        case (csr_addr)
                            A_MSTATUS: begin
                                r_mstatus_mie  <= w_wval[3];
                                r_mstatus_mpie <= w_wval[7];
                            end
                            A_MIE:      r_meie     <= w_wval[11];
                            A_MTVEC:    r_mtvec    <= w_wval;
                            A_MSCRATCH: r_mscratch <= w_wval;
                            A_MEPC:     r_mepc     <= w_wval;
                            A_MCAUSE: begin
                                r_mcause_int  <= w_wval[XLEN-1];
                                r_mcause_code <= w_wval[3:0];
                            end
                            A_MTVAL:    r_mtval    <= w_wval;
                            default:    ;
                        endcase
                    end
                end
                S_SAVE: begin
                    r_state       <= S_JUMP;
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= w_trap_target;
                end
                S_JUMP: begin
                    r_state    <= S_IDLE;
                    r_stall    <= 1'b0;
                    r_redirect <= 1'b0;
                end
                S_RET: begin
                    r_state        <= S_IDLE;
                    r_redirect     <= 1'b0;
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall       = r_stall;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed self-checking bench for trap_csr_unit: CSR ops, exception, vectored interrupt,
// mret, trap/CSR collisions and asynchronous reset mid-sequence.
module tb_trap_csr_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            irq_ext;
    logic [XLEN-1:0] retire_pc;
    logic            mret;
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    trap_csr_unit #(.XLEN(XLEN), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_pc      (exc_pc),
        .exc_tval    (exc_tval),
        .irq_ext     (irq_ext),
        .retire_pc   (retire_pc),
        .mret        (mret),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [XLEN-1:0] data);
        csr_en   = 1'b1;
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
        data   = csr_rdata;
        csr_en = 1'b0;
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] addr,
                             input logic [XLEN-1:0] wdata, output logic [XLEN-1:0] old);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        #1;
        old = csr_rdata;
        tick();
        csr_en    = 1'b0;
        csr_op    = 2'b00;
        csr_wdata = '0;
    endtask

    initial begin
        logic [XLEN-1:0] d;

        rst       = 1'b0;
        exc_valid = 1'b0;
        exc_cause = '0;
        exc_pc    = '0;
        exc_tval  = '0;
        irq_ext   = 1'b0;
        retire_pc = '0;
        mret      = 1'b0;
        csr_en    = 1'b0;
        csr_op    = 2'b00;
        csr_addr  = '0;
        csr_wdata = '0;

        // Reset state
        #3;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_illegal", {31'b0, csr_illegal}, 32'h0);
        csr_read(12'h305, d); check("rst_mtvec", d, 32'h0000_0000);
        csr_read(12'h300, d); check("rst_mstatus", d, 32'h0000_1800);
        tick();
        rst = 1'b1;
        tick();

        // CSR RW / RS / RC and illegal address
        csr_write(2'b01, 12'h340, 32'hA5A5_0000, d); check("rw_old", d, 32'h0);
        csr_write(2'b10, 12'h340, 32'h0000_00FF, d); check("rs_old", d, 32'hA5A5_0000);
        csr_read(12'h340, d); check("rs_new", d, 32'hA5A5_00FF);
        csr_write(2'b11, 12'h340, 32'hA500_0000, d); check("rc_old", d, 32'hA5A5_00FF);
        csr_read(12'h340, d); check("rc_new", d, 32'h00A5_00FF);
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1234_5678;
        #1;
        check("illegal_flag", {31'b0, csr_illegal}, 32'h1);
        check("illegal_rdata", csr_rdata, 32'h0);
        tick();
        csr_en = 1'b0; csr_op = 2'b00;
        csr_read(12'h340, d); check("illegal_nochange", d, 32'h00A5_00FF);
        csr_write(2'b01, 12'h341, 32'h0000_0047, d);
        csr_read(12'h341, d); check("mepc_align", d, 32'h0000_0044);
        csr_write(2'b01, 12'h344, 32'hFFFF_FFFF, d);
        csr_read(12'h344, d); check("mip_ro", d, 32'h0);

        // Synchronous exception
        csr_write(2'b01, 12'h305, 32'h0000_0100, d);
        csr_write(2'b01, 12'h300, 32'h0000_0008, d);
        csr_read(12'h300, d); check("mstatus_mie1", d, 32'h0000_1808);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
        tick();
        exc_valid = 1'b0;
        check("exc_n1_stall", {31'b0, stall}, 32'h1);
        check("exc_n1_redirect", {31'b0, redirect}, 32'h0);
        tick();
        check("exc_n2_stall", {31'b0, stall}, 32'h1);
        check("exc_n2_redirect", {31'b0, redirect}, 32'h1);
        check("exc_n2_pc", redirect_pc, 32'h0000_0100);
        tick();
        check("exc_n3_stall", {31'b0, stall}, 32'h0);
        check("exc_n3_redirect", {31'b0, redirect}, 32'h0);
        csr_read(12'h341, d); check("exc_mepc", d, 32'h40);
        csr_read(12'h342, d); check("exc_mcause", d, 32'h2);
        csr_read(12'h343, d); check("exc_mtval", d, 32'hDEAD);
        csr_read(12'h300, d); check("exc_mstatus", d, 32'h0000_1880);

        // mret
        csr_write(2'b01, 12'h341, 32'h44, d);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_redirect", {31'b0, redirect}, 32'h1);
        check("mret_stall", {31'b0, stall}, 32'h0);
        check("mret_pc", redirect_pc, 32'h44);
        tick();
        check("mret_done", {31'b0, redirect}, 32'h0);
        csr_read(12'h300, d); check("mret_mstatus", d, 32'h0000_1888);

        // Vectored external interrupt
        csr_write(2'b01, 12'h305, 32'h0000_0201, d);
        csr_write(2'b01, 12'h304, 32'h0000_0800, d);
        irq_ext = 1'b1; retire_pc = 32'h88;
        tick();
        csr_read(12'h344, d); check("mip_meip", d, 32'h800);
        irq_ext = 1'b0;
        check("irq_stall", {31'b0, stall}, 32'h1);
        tick();
        check("irq_redirect", {31'b0, redirect}, 32'h1);
        check("irq_pc", redirect_pc, 32'h0000_022C);
        tick();
        csr_read(12'h342, d); check("irq_mcause", d, 32'h8000_000B);
        csr_read(12'h341, d); check("irq_mepc", d, 32'h88);
        csr_read(12'h343, d); check("irq_mtval", d, 32'h0);

        // Interrupt pending with MIE=0 must not be taken
        irq_ext = 1'b1;
        tick();
        check("irq_masked_stall", {31'b0, stall}, 32'h0);
        tick();
        tick();
        check("irq_masked_redirect", {31'b0, redirect}, 32'h0);
        irq_ext = 1'b0;

        // Collision: exception beats irq, mret and CSR write
        csr_write(2'b01, 12'h300, 32'h0000_0008, d);
        csr_write(2'b01, 12'h305, 32'h0000_0100, d);
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h60; exc_tval = 32'h1;
        irq_ext = 1'b1; mret = 1'b1;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
        tick();
        exc_valid = 1'b0; irq_ext = 1'b0; mret = 1'b0;
        csr_en = 1'b0; csr_op = 2'b00;
        check("coll_stall", {31'b0, stall}, 32'h1);
        check("coll_no_ret", {31'b0, redirect}, 32'h0);
        tick();
        check("coll_pc", redirect_pc, 32'h0000_0100);
        tick();
        csr_read(12'h342, d); check("coll_mcause", d, 32'h5);
        csr_read(12'h340, d); check("coll_mscratch", d, 32'h00A5_00FF);

        // Asynchronous reset during SAVE
        exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h70; exc_tval = 32'h2;
        tick();
        exc_valid = 1'b0;
        check("rstmid_save", {31'b0, stall}, 32'h1);
        rst = 1'b0;
        #1;
        check("rstmid_stall", {31'b0, stall}, 32'h0);
        check("rstmid_pc", redirect_pc, 32'h0);
        rst = 1'b1;
        tick();
        check("rstmid_redirect1", {31'b0, redirect}, 32'h0);
        tick();
        check("rstmid_redirect2", {31'b0, redirect}, 32'h0);
        csr_read(12'h305, d); check("rstmid_mtvec", d, 32'h0);
        csr_read(12'h340, d); check("rstmid_mscratch", d, 32'h0);
        csr_read(12'h341, d); check("rstmid_mepc", d, 32'h0);
        csr_read(12'h300, d); check("rstmid_mstatus", d, 32'h0000_1800);
        csr_read(12'h304, d); check("rstmid_mie", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
